// File: rtl/usb_fs_tx.sv
// Full-speed USB serial transmitter: SYNC, NRZI with bit stuffing, EOP.
// Drives the FS line pair and driver enable from a valid/ready byte stream.
module usb_fs_tx #(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic       clk_60m_usb,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_enable,
  output logic       dp_bit_fs_phy,
  output logic       dm_bit_fs_phy
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SYNC    = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] EOP_SE0 = 3'd3;
  localparam logic [2:0] EOP_J   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    ones_q, ones_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          dp_d, dm_d, en_d, busy_d, ready_d;
  logic          bit_tick, fetch_due, do_fetch, send_en, send_bit;

  assign bit_tick  = (cnt_q == CW'(CLK_DIV - 1));
  // The current bit is the last one before a byte fetch (no stuff bit still owed)
  assign fetch_due = ((state_q == SYNC) && (idx_q == 3'd7)) ||
                     ((state_q == DATA) && (idx_q == 3'd7) && (ones_q != 3'd6));

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ones_d   = ones_q;
    shreg_d  = shreg_q;
    dp_d     = dp_bit_fs_phy;
    dm_d     = dm_bit_fs_phy;
    en_d     = tx_enable;
    busy_d   = tx_busy;
    ready_d  = fetch_due && tx_valid && (cnt_q == CW'(CLK_DIV - 2));
    do_fetch = 1'b0;
    send_en  = 1'b0;
    send_bit = 1'b0;

    if (state_q != IDLE) cnt_d = bit_tick ? '0 : CW'(cnt_q + 1'b1);

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = SYNC;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          idx_d   = 3'd0;
          ones_d  = 3'd0;
          send_en = 1'b1;
        end
      end
      SYNC: begin
        if (bit_tick) begin
          if (idx_q == 3'd7) begin
            do_fetch = 1'b1;
          end else begin
            idx_d    = 3'(idx_q + 3'd1);
            send_en  = 1'b1;
            send_bit = (idx_q == 3'd6);
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (ones_q == 3'd6) begin
            send_en = 1'b1;
          end else if (idx_q == 3'd7) begin
            do_fetch = 1'b1;
          end else begin
            idx_d    = 3'(idx_q + 3'd1);
            send_en  = 1'b1;
            send_bit = shreg_q[0];
            shreg_d  = {1'b0, shreg_q[7:1]};
          end
        end
      end
      EOP_SE0: begin
        if (bit_tick) begin
          if (idx_q == 3'd1) begin
            state_d = EOP_J;
            dp_d    = 1'b1;
            dm_d    = 1'b0;
          end else begin
            idx_d = 3'(idx_q + 3'd1);
          end
        end
      end
      EOP_J: begin
        if (bit_tick) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx_ready was raised one cycle ahead, so it marks an accepted byte here
    if (do_fetch) begin
      idx_d = 3'd0;
      if (tx_ready) begin
        state_d  = DATA;
        send_en  = 1'b1;
        send_bit = tx_data[0];
        shreg_d  = {1'b0, tx_data[7:1]};
      end else begin
        state_d = EOP_SE0;
        dp_d    = 1'b0;
        dm_d    = 1'b0;
      end
    end

    // NRZI: a zero swaps J/K, a one holds the level
    if (send_en) begin
      if (!send_bit) begin
        dp_d = dm_bit_fs_phy;
        dm_d = dp_bit_fs_phy;
      end
      ones_d = send_bit ? 3'(ones_q + 3'd1) : 3'd0;
    end
  end

  always_ff @(posedge clk_60m_usb or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      ones_q        <= 3'd0;
      shreg_q       <= 8'd0;
      dp_bit_fs_phy <= 1'b1;
      dm_bit_fs_phy <= 1'b0;
      tx_enable     <= 1'b0;
      tx_busy       <= 1'b0;
      tx_ready      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      ones_q        <= ones_d;
      shreg_q       <= shreg_d;
      dp_bit_fs_phy <= dp_d;
      dm_bit_fs_phy <= dm_d;
      tx_enable     <= en_d;
      tx_busy       <= busy_d;
      tx_ready      <= ready_d;
    end
  end

endmodule
